// File: rtl/xor_stream_unit.sv
// xor_stream_unit
//   Registered WIDTH-bit XOR stage behind a valid/ready handshake. In per-beat mode (mode=0) each
//   accepted beat yields a^b one cycle later. In frame-checksum mode (mode=1, sampled on the first
//   beat of a frame) every beat of the frame is folded into an accumulator seeded with ACC_INIT.
//   One result is emitted when the beat with in_last=1 is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit can accept a beat this cycle
//   mode       0 = per-beat XOR, 1 = frame checksum
//   a, b       operands
//   in_last    final beat of a frame (mode 1 only)
//   abort      discard any open frame; blocks acceptance this cycle
//   out_valid  result valid
//   out_ready  downstream accepts result
//   y          result word
//   parity     reduction XOR of y
//   out_beats  beats folded into y, saturating
module xor_stream_unit #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       CNT_W    = 8,
  parameter logic [WIDTH-1:0]  ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] acc_xor;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !abort && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Operands are only used under accept, so X on a/b while idle never reaches state.
  assign ab      = a ^ b;
  assign acc_xor = acc_q ^ ab;
  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    beats_d = beats_q;
    load    = 1'b0;

    if (abort) begin
      // Output register is untouched so a pending result still completes.
      state_d = StIdle;
      acc_d   = ACC_INIT;
      cnt_d   = '0;
    end else if (accept) begin
      case (state_q)
        StIdle: begin
          if (!mode) begin
            load    = 1'b1;
            y_d     = ab;
            beats_d = CntOne;
          end else if (in_last) begin
            load    = 1'b1;
            y_d     = ACC_INIT ^ ab;
            beats_d = CntOne;
          end else begin
            acc_d   = ACC_INIT ^ ab;
            cnt_d   = CntOne;
            state_d = StAccum;
          end
        end
        StAccum: begin
          if (!in_last) begin
            acc_d = acc_xor;
            cnt_d = cnt_inc;
          end else begin
            load    = 1'b1;
            y_d     = acc_xor;
            beats_d = cnt_inc;
            acc_d   = ACC_INIT;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    parity_d = load ? ^y_d : parity_q;
    // A new result keeps valid high; otherwise it drops once consumed.
    valid_d  = load || (valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= ACC_INIT;
      cnt_q    <= '0;
      y_q      <= '0;
      parity_q <= 1'b0;
      beats_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      parity_q <= parity_d;
      beats_q  <= beats_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign parity    = parity_q;
  assign out_beats = beats_q;

endmodule

// File: tb/tb_xor_stream_unit.sv
module tb_xor_stream_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;
  localparam logic [WIDTH-1:0] ACC_INIT = 8'h5A;
  localparam int unsigned SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_last;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic [CNT_W-1:0] out_beats;

  xor_stream_unit #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .ACC_INIT(ACC_INIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .in_last  (in_last),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .parity   (parity),
    .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             p;
    int unsigned      n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference frame state: running XOR of the open frame and its beat count.
  bit               frame_open = 1'b0;
  logic [WIDTH-1:0] frame_acc;
  int unsigned      frame_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] val, input int unsigned n);
    exp_t e;
    e.y = val;
    e.p = ^val;
    e.n = (n > SAT) ? SAT : n;
    return e;
  endfunction

  // Model: inputs are stable at the posedge; the monitor has already popped a consumed result,
  // so an empty queue here means the output slot is free this cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      frame_open = 1'b0;
    end else if (abort) begin
      frame_open = 1'b0;
    end else if (in_valid && sb.size() == 0) begin
      if (!frame_open) begin
        if (!mode) begin
          sb.push_back(mk(a ^ b, 1));
        end else begin
          frame_acc = ACC_INIT ^ a ^ b;
          frame_n   = 1;
          if (in_last) sb.push_back(mk(frame_acc, 1));
          else frame_open = 1'b1;
        end
      end else begin
        frame_acc = frame_acc ^ a ^ b;
        frame_n++;
        if (in_last) begin
          sb.push_back(mk(frame_acc, frame_n));
          frame_open = 1'b0;
        end
      end
    end
  end

  // Monitor: compares the presented result against the queue head, pops on handshake.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(!abort && (sb.size() == 0 || out_ready)));
    if (out_valid && sb.size() != 0) begin
      chk("y", 32'(y), 32'(sb[0].y));
      chk("parity", 32'(parity), 32'(sb[0].p));
      chk("out_beats", 32'(out_beats), sb[0].n);
      if (out_ready) void'(sb.pop_front());
    end
  end

  task automatic step(input logic v, input logic m, input logic [WIDTH-1:0] av,
                      input logic [WIDTH-1:0] bv, input logic last, input logic ab,
                      input logic ordy);
    in_valid  = v;
    mode      = m;
    a         = av;
    b         = bv;
    in_last   = last;
    abort     = ab;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_reset_state();
    rst_n = 1'b1;

    // Per-beat XOR.
    step(1'b1, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1);
    chk("t1_y", 32'(y), 32'hCC);
    chk("t1_beats", 32'(out_beats), 32'd1);
    idle(2);

    // Three-beat checksum frame.
    step(1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t2_y", 32'(y), 32'(ACC_INIT ^ 8'h07));
    chk("t2_beats", 32'(out_beats), 32'd3);
    idle(2);

    // Backpressure, then consume and accept in the same cycle.
    step(1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("t3_hold_y", 32'(y), 32'h33);
    step(1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    chk("t3_nobubble_y", 32'(y), 32'h77);
    idle(2);

    // Abort mid-frame; the abort beat itself is not taken.
    step(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hF0, 8'h02, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t4_y", 32'(y), 32'(ACC_INIT ^ 8'hAA));
    chk("t4_beats", 32'(out_beats), 32'd1);
    idle(2);

    // Six-beat frame saturates the 2-bit counter.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'h11, 8'h00, i == 5, 1'b0, 1'b1);
    chk("t5_y", 32'(y), 32'(ACC_INIT));
    chk("t5_beats", 32'(out_beats), 32'(SAT));
    idle(2);

    // Reset while a frame is open and a result is pending.
    step(1'b1, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_reset_state();
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t6_y", 32'(y), 32'(ACC_INIT ^ 8'h0F));
    idle(2);

    // Randomized traffic with occasional aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      step(1'($urandom_range(3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(3) == 0), 1'($urandom_range(19) == 0),
           1'($urandom_range(3) != 0));
    end
    rst_n = 1'b1;
    idle(5);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
